rvv_rt_trace_buf: RTL and testbench
===================================

# rvv_rt_trace_buf

Parametrised retire-trace buffer for the RVV backend. It passively observes N retire lanes (ROB-to-retire handshakes plus their VRF write payload) and compacts every fired lane, in lane order, into a circular buffer. Consumers drain the buffer one entry per cycle over a valid/ready port. The block also keeps retired-instruction, drop and vxsat statistics. It generalises the fixed 4-lane, unbuffered retire monitoring in the backend bench top into reusable synthesizable RTL with configurable lane count, depth and data width.

## Interface
Parameters:
- NUM_LANES, 4, retire lanes observed per cycle (1..8)
- DEPTH, 16, buffer entries; power of two, >= NUM_LANES
- DATA_W, 128, VRF write data width (VLEN); strobe width DATA_W/8
- PC_W, 32, uop PC width (used only with RT_TRACE_PC_EN)

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  capture enable; when 0, fired lanes are neither stored nor counted
- rt_valid  in  NUM_LANES  ROB-to-retire valid per lane
- rt_ready  in  NUM_LANES  retire-to-ROB ready per lane
- rt_last  in  NUM_LANES  lane carries the last uop of an instruction
- rt_vxsat  in  NUM_LANES  lane saturated
- rt_index  in  NUM_LANES x 5  destination vreg index
- rt_strobe  in  NUM_LANES x DATA_W/8  byte write enables
- rt_data  in  NUM_LANES x DATA_W  write data
- rt_pc  in  NUM_LANES x PC_W  uop PC (present only with RT_TRACE_PC_EN)
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_entry  out  rt_trace_entry_t  head entry {index, strobe, data, last, vxsat[, pc], lane}
- count  out  $clog2(DEPTH)+1  occupied entries
- inst_retired  out  32  fired lanes with rt_last; wraps
- drop_cnt  out  16  lanes dropped on overflow; saturates at 16'hFFFF
- overflow  out  1  sticky, set on any drop
- vxsat_sticky  out  1  sticky OR of fired rt_vxsat
- clr_stat  in  1  clears overflow, vxsat_sticky, drop_cnt, inst_retired

## Operation
- fire[i] = rt_valid[i] & rt_ready[i] & enable. k = popcount(fire).
- Fired lanes are written in ascending lane order to wr_ptr .. wr_ptr+k-1 mod DEPTH. The lane field records the source lane number.
- Free space is computed as DEPTH - count, taken before this cycle's pop. Space freed by a same-cycle pop is not usable until the next cycle.
- If k > free: only the lowest-numbered `free` lanes are stored. The remaining lanes are dropped, drop_cnt += dropped count, and overflow is set.
- Pop occurs when out_valid & out_ready; rd_ptr then advances by 1.
- Pointers wrap modulo DEPTH. count_next = count + stored - pop.
- inst_retired counts every fired lane with rt_last, including dropped lanes.
- vxsat_sticky |= |(fire & rt_vxsat).
- If clr_stat and an update land in the same cycle, the update wins: a new drop or vxsat re-sets the flag, and the counters load the current cycle's increment.

## Timing
- Reset values: out_valid 0, count 0, pointers 0, inst_retired 0, drop_cnt 0, overflow 0, vxsat_sticky 0. out_entry holds its last value and is don't-care while out_valid is 0.
- Write-to-out_valid latency: 1 cycle. There is no bypass when the buffer is empty.
- out_valid = (count != 0). out_entry is stable while out_valid & !out_ready.
- Full (count == DEPTH): all fired lanes drop. A pop in the same cycle still completes.
- Reset asserted mid-operation discards all entries. Reset takes priority over every other input.
- enable falling takes effect in the same cycle. It does not affect the drain port.

## Configuration
- RT_TRACE_PC_EN defined: the rt_pc port exists, each entry stores pc, and out_entry.pc is valid.
- RT_TRACE_PC_EN undefined: no rt_pc port, no pc field in rt_trace_entry_t, and no pc storage.

## Structure
- Package rvv_rt_trace_pkg holds:
  - rt_trace_entry_t, with the pc field under RT_TRACE_PC_EN
  - the lane-number width
  - the VRF index width constant (5)
- Sub-module rvv_rt_compact takes fire and free count. It outputs:
  - per-lane write offsets (exclusive prefix sum)
  - a per-lane store mask
  - the stored count and the dropped count
- The top level holds the buffer storage, the pointers and the statistics registers.

## Test plan
- Single lane 2 fires once, rt_last=1, index=7, then out_ready=1 → out_valid rises the next cycle with index 7, lane 2; inst_retired=1; count returns to 0 after the pop.
- All 4 lanes fire in one cycle with indices 1,2,3,4 → four pops return 1,2,3,4 in that order on consecutive cycles.
- DEPTH=16 with 14 entries held, 4 lanes fire, no pop → lanes 0,1 stored, count=16, drop_cnt=2, overflow=1. clr_stat next cycle → overflow=0, drop_cnt=0.
- Full buffer, pop and 1 lane firing in the same cycle → lane dropped, count=15. The following cycle a fire stores and count=16.
- Fill 10 entries, assert rst for 1 cycle mid-drain → out_valid=0, count=0, all statistics 0 on the next cycle.
- With RT_TRACE_PC_EN: lane 3 fires with pc=32'h8000_0040 → popped entry pc=32'h8000_0040, lane=3.

Source files
------------

// File: rtl/rvv_rt_trace_pkg.sv
// Shared types for the RVV retire-trace buffer.
// With RT_TRACE_PC_EN defined, each trace entry also carries the uop PC.
package rvv_rt_trace_pkg;

    localparam int RT_IDX_W  = 5;
    localparam int RT_LANE_W = 3;    // enough for lane numbers 0..7
    localparam int RT_DATA_W = 128;
    localparam int RT_PC_W   = 32;

    typedef struct packed {
        logic [RT_IDX_W-1:0]    index;
        logic [RT_DATA_W/8-1:0] strobe;
        logic [RT_DATA_W-1:0]   data;
        logic                   last;
        logic                   vxsat;
`ifdef RT_TRACE_PC_EN
        logic [RT_PC_W-1:0]     pc;
`endif
        logic [RT_LANE_W-1:0]   lane;
    } rt_trace_entry_t;

endpackage

// File: rtl/rvv_rt_compact.sv
// Lane compaction: maps fired lanes onto consecutive buffer slots and splits
// them into stored / dropped according to the free space.
module rvv_rt_compact #(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 5
) (
    input  logic [NUM_LANES-1:0]            fire,
    input  logic [CNT_W-1:0]                free_cnt,
    output logic [NUM_LANES-1:0][CNT_W-1:0] offset,
    output logic [NUM_LANES-1:0]            store,
    output logic [CNT_W-1:0]                stored_cnt,
    output logic [CNT_W-1:0]                dropped_cnt
);

    logic [CNT_W-1:0] run;

    // offset[i] counts fired lanes below i, so stores are always the lowest lanes
    always_comb begin
        run         = '0;
        offset      = '0;
        store       = '0;
        stored_cnt  = '0;
        dropped_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            offset[i] = run;
            store[i]  = fire[i] && (run < free_cnt);
            if (fire[i]) begin
                run = run + CNT_W'(1);
                if (store[i]) stored_cnt  = stored_cnt + CNT_W'(1);
                else          dropped_cnt = dropped_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rvv_rt_trace_buf.sv
// Retire-trace buffer: compacts fired retire lanes into a circular buffer and
// keeps retire/drop/vxsat statistics. Optional RT_TRACE_PC_EN adds uop PC capture.
module rvv_rt_trace_buf
    import rvv_rt_trace_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DEPTH     = 16,
    parameter int DATA_W    = RT_DATA_W,
    parameter int PC_W      = RT_PC_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [NUM_LANES-1:0]               rt_valid,
    input  logic [NUM_LANES-1:0]               rt_ready,
    input  logic [NUM_LANES-1:0]               rt_last,
    input  logic [NUM_LANES-1:0]               rt_vxsat,
    input  logic [NUM_LANES-1:0][RT_IDX_W-1:0] rt_index,
    input  logic [NUM_LANES-1:0][DATA_W/8-1:0] rt_strobe,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]   rt_data,
`ifdef RT_TRACE_PC_EN
    input  logic [NUM_LANES-1:0][PC_W-1:0]     rt_pc,
`endif
    output logic                               out_valid,
    input  logic                               out_ready,
    output rt_trace_entry_t                    out_entry,
    output logic [$clog2(DEPTH):0]             count,
    output logic [31:0]                        inst_retired,
    output logic [15:0]                        drop_cnt,
    output logic                               overflow,
    output logic                               vxsat_sticky,
    input  logic                               clr_stat
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry field widths come from the package; these parameters must agree with it.
    localparam bit CFG_MATCH = (DATA_W == RT_DATA_W) && (PC_W == RT_PC_W) && (NUM_LANES <= 8);
    if (!CFG_MATCH) begin : g_cfg_mismatch_unsupported
    end

    logic [NUM_LANES-1:0]            fire;
    logic [NUM_LANES-1:0]            store;
    logic [NUM_LANES-1:0][CNT_W-1:0] offset;
    logic [CNT_W-1:0]                free_cnt, stored_cnt, dropped_cnt;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx;
    logic                            pop;
    rt_trace_entry_t                 lane_entry [NUM_LANES];
    rt_trace_entry_t                 mem_q [DEPTH];
    rt_trace_entry_t                 mem_d [DEPTH];
    logic [31:0]                     inst_retired_q, inst_retired_d, inst_inc;
    logic [15:0]                     drop_cnt_q, drop_cnt_d;
    logic [16:0]                     drop_sum;
    logic                            overflow_q, overflow_d, vxsat_q, vxsat_d;

    assign fire     = rt_valid & rt_ready & {NUM_LANES{enable}};
    assign free_cnt = CNT_W'(DEPTH) - count_q;

    rvv_rt_compact #(.NUM_LANES(NUM_LANES), .CNT_W(CNT_W)) u_compact (
        .fire        (fire),
        .free_cnt    (free_cnt),
        .offset      (offset),
        .store       (store),
        .stored_cnt  (stored_cnt),
        .dropped_cnt (dropped_cnt)
    );

    // Drain port: head entry transfers on out_valid & out_ready; out_valid never waits on out_ready.
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_entry = mem_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_entry[i].index  = rt_index[i];
            lane_entry[i].strobe = rt_strobe[i];
            lane_entry[i].data   = rt_data[i];
            lane_entry[i].last   = rt_last[i];
            lane_entry[i].vxsat  = rt_vxsat[i];
`ifdef RT_TRACE_PC_EN
            lane_entry[i].pc     = rt_pc[i];
`endif
            lane_entry[i].lane   = RT_LANE_W'(i);
        end
    end

    always_comb begin
        mem_d  = mem_q;
        wr_idx = wr_ptr_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (store[i]) begin
                wr_idx        = wr_ptr_q + offset[i][PTR_W-1:0];
                mem_d[wr_idx] = lane_entry[i];
            end
        end
        wr_ptr_d = wr_ptr_q + stored_cnt[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + stored_cnt - CNT_W'(pop);
    end

    // Statistics: a same-cycle update wins over clr_stat.
    always_comb begin
        inst_inc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            inst_inc = inst_inc + 32'(fire[i] & rt_last[i]);
        end
        inst_retired_d = (clr_stat ? 32'd0 : inst_retired_q) + inst_inc;
        drop_sum       = {1'b0, (clr_stat ? 16'd0 : drop_cnt_q)} + 17'(dropped_cnt);
        drop_cnt_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d     = (overflow_q & ~clr_stat) | (dropped_cnt != '0);
        vxsat_d        = (vxsat_q & ~clr_stat) | (|(fire & rt_vxsat));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inst_retired_q <= '0;
            drop_cnt_q     <= '0;
            overflow_q     <= 1'b0;
            vxsat_q        <= 1'b0;
        end else begin
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            inst_retired_q <= inst_retired_d;
            drop_cnt_q     <= drop_cnt_d;
            overflow_q     <= overflow_d;
            vxsat_q        <= vxsat_d;
        end
    end

    // Storage is not reset: entries are only observable through count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count        = count_q;
    assign inst_retired = inst_retired_q;
    assign drop_cnt     = drop_cnt_q;
    assign overflow     = overflow_q;
    assign vxsat_sticky = vxsat_q;

endmodule

// File: tb/tb_rvv_rt_trace_buf.sv
// Self-checking bench for rvv_rt_trace_buf: queue-based reference model plus
// directed scenarios and randomized traffic. Covers RT_TRACE_PC_EN when defined.
module tb_rvv_rt_trace_buf;
    import rvv_rt_trace_pkg::*;

    localparam int NL      = 4;
    localparam int DEPTH   = 16;
    localparam int ENTRY_W = $bits(rt_trace_entry_t);

    logic                 clk = 1'b0;
    logic                 rst, enable, out_ready, clr_stat;
    logic [NL-1:0]        rt_valid, rt_ready, rt_last, rt_vxsat;
    logic [NL-1:0][4:0]   rt_index;
    logic [NL-1:0][15:0]  rt_strobe;
    logic [NL-1:0][127:0] rt_data;
`ifdef RT_TRACE_PC_EN
    logic [NL-1:0][31:0]  rt_pc;
`endif
    logic                 out_valid;
    rt_trace_entry_t      out_entry;
    logic [4:0]           count;
    logic [31:0]          inst_retired;
    logic [15:0]          drop_cnt;
    logic                 overflow, vxsat_sticky;

    rvv_rt_trace_buf #(.NUM_LANES(NL), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rt_valid     (rt_valid),
        .rt_ready     (rt_ready),
        .rt_last      (rt_last),
        .rt_vxsat     (rt_vxsat),
        .rt_index     (rt_index),
        .rt_strobe    (rt_strobe),
        .rt_data      (rt_data),
`ifdef RT_TRACE_PC_EN
        .rt_pc        (rt_pc),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_entry    (out_entry),
        .count        (count),
        .inst_retired (inst_retired),
        .drop_cnt     (drop_cnt),
        .overflow     (overflow),
        .vxsat_sticky (vxsat_sticky),
        .clr_stat     (clr_stat)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    logic [ENTRY_W-1:0] exp_q[$];
    logic [31:0]        m_inst;
    int                 m_drop;
    logic               m_ovf, m_vx;
    int                 checks = 0;
    int                 errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] make_entry(input int i);
        rt_trace_entry_t e;
        e.index  = rt_index[i];
        e.strobe = rt_strobe[i];
        e.data   = rt_data[i];
        e.last   = rt_last[i];
        e.vxsat  = rt_vxsat[i];
`ifdef RT_TRACE_PC_EN
        e.pc     = rt_pc[i];
`endif
        e.lane   = 3'(i);
        return e;
    endfunction

    task automatic model_check();
        chk("out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
        chk("count", 256'(count), 256'(exp_q.size()));
        if (exp_q.size() != 0) chk("out_entry", 256'(out_entry), 256'(exp_q[0]));
        chk("inst_retired", 256'(inst_retired), 256'(m_inst));
        chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
        chk("overflow", 256'(overflow), 256'(m_ovf));
        chk("vxsat_sticky", 256'(vxsat_sticky), 256'(m_vx));
    endtask

    // Abstract rules: free space seen before the pop, lanes stored lowest-first.
    task automatic model_update();
        int free_n, stored, dropped;
        logic [31:0] inc;
        logic vxh;
        if (rst) begin
            exp_q.delete();
            m_inst = '0; m_drop = 0; m_ovf = 1'b0; m_vx = 1'b0;
            return;
        end
        free_n = DEPTH - exp_q.size();
        stored = 0; dropped = 0; inc = '0; vxh = 1'b0;
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        for (int i = 0; i < NL; i++) begin
            if (enable && rt_valid[i] && rt_ready[i]) begin
                if (rt_last[i]) inc++;
                if (rt_vxsat[i]) vxh = 1'b1;
                if (stored < free_n) begin
                    exp_q.push_back(make_entry(i));
                    stored++;
                end else begin
                    dropped++;
                end
            end
        end
        if (clr_stat) begin
            m_inst = '0; m_drop = 0; m_ovf = 1'b0; m_vx = 1'b0;
        end
        m_inst = m_inst + inc;
        m_drop = (m_drop + dropped > 65535) ? 65535 : m_drop + dropped;
        if (dropped != 0) m_ovf = 1'b1;
        if (vxh) m_vx = 1'b1;
    endtask

    // One clock: compare away from the edge, advance the model, then let the DUT clock.
    task automatic step();
        @(negedge clk);
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        rst = 1'b0; enable = 1'b1; out_ready = 1'b0; clr_stat = 1'b0;
        rt_valid = '0; rt_ready = '0; rt_last = '0; rt_vxsat = '0;
    endtask

    task automatic set_lane(input int i, input logic [4:0] idx, input logic last);
        rt_valid[i]  = 1'b1;
        rt_ready[i]  = 1'b1;
        rt_index[i]  = idx;
        rt_last[i]   = last;
        rt_vxsat[i]  = 1'b0;
        rt_strobe[i] = 16'($urandom);
        rt_data[i]   = {$urandom, $urandom, $urandom, $urandom};
`ifdef RT_TRACE_PC_EN
        rt_pc[i]     = $urandom;
`endif
    endtask

    task automatic fill(input int n);
        int left;
        left = n;
        while (left > 0) begin
            idle();
            for (int i = 0; i < NL && left > 0; i++) begin
                set_lane(i, 5'($urandom), 1'($urandom));
                left--;
            end
            step();
        end
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rt_index = '0; rt_strobe = '0; rt_data = '0;
`ifdef RT_TRACE_PC_EN
        rt_pc = '0;
`endif
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        step();
        step();
        idle();
        chk("reset_count", 256'(count), 256'(0));
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        chk("reset_inst_retired", 256'(inst_retired), 256'(0));
        chk("reset_overflow", 256'(overflow), 256'(0));

        // Single lane 2, last, index 7
        set_lane(2, 5'd7, 1'b1);
        step();
        idle();
        out_ready = 1'b1;
        chk("t1_out_valid", 256'(out_valid), 256'(1));
        chk("t1_index", 256'(out_entry.index), 256'(7));
        chk("t1_lane", 256'(out_entry.lane), 256'(2));
        chk("t1_inst_retired", 256'(inst_retired), 256'(1));
        step();
        idle();
        chk("t1_count_after_pop", 256'(count), 256'(0));

        // Four lanes at once, popped in lane order
        for (int i = 0; i < NL; i++) set_lane(i, 5'(i + 1), 1'b0);
        step();
        idle();
        out_ready = 1'b1;
        for (int k = 0; k < NL; k++) begin
            chk("t2_index", 256'(out_entry.index), 256'(k + 1));
            chk("t2_lane", 256'(out_entry.lane), 256'(k));
            step();
        end
        idle();
        chk("t2_count_empty", 256'(count), 256'(0));

        // 14 held, 4 fire, no pop: two stored, two dropped
        fill(14);
        chk("t3_count14", 256'(count), 256'(14));
        for (int i = 0; i < NL; i++) set_lane(i, 5'(20 + i), 1'b0);
        step();
        idle();
        chk("t3_count_full", 256'(count), 256'(16));
        chk("t3_drop_cnt", 256'(drop_cnt), 256'(2));
        chk("t3_overflow", 256'(overflow), 256'(1));
        clr_stat = 1'b1;
        step();
        idle();
        chk("t3_clr_overflow", 256'(overflow), 256'(0));
        chk("t3_clr_drop_cnt", 256'(drop_cnt), 256'(0));

        // Full: pop and fire in one cycle drops the lane; next cycle stores
        out_ready = 1'b1;
        set_lane(0, 5'd9, 1'b0);
        step();
        idle();
        chk("t4_count15", 256'(count), 256'(15));
        chk("t4_drop_cnt", 256'(drop_cnt), 256'(1));
        set_lane(0, 5'd10, 1'b0);
        step();
        idle();
        chk("t4_count16", 256'(count), 256'(16));

        // Reset mid-drain
        rst = 1'b1;
        step();
        idle();
        fill(8);
        set_lane(0, 5'd1, 1'b1);
        rt_vxsat[0] = 1'b1;
        set_lane(1, 5'd2, 1'b0);
        step();
        idle();
        chk("t5_count10", 256'(count), 256'(10));
        chk("t5_vxsat", 256'(vxsat_sticky), 256'(1));
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        idle();
        chk("t5_out_valid", 256'(out_valid), 256'(0));
        chk("t5_count", 256'(count), 256'(0));
        chk("t5_inst_retired", 256'(inst_retired), 256'(0));
        chk("t5_drop_cnt", 256'(drop_cnt), 256'(0));
        chk("t5_vxsat_clr", 256'(vxsat_sticky), 256'(0));

`ifdef RT_TRACE_PC_EN
        set_lane(3, 5'd5, 1'b1);
        rt_pc[3] = 32'h8000_0040;
        step();
        idle();
        chk("t6_pc", 256'(out_entry.pc), 256'(32'h8000_0040));
        chk("t6_lane", 256'(out_entry.lane), 256'(3));
        out_ready = 1'b1;
        step();
        idle();
`endif

        // Randomized traffic with phases of differing drain pressure
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 400; c++) begin
                rst       = ($urandom_range(0, 499) == 0);
                enable    = ($urandom_range(0, 9) != 0);
                clr_stat  = ($urandom_range(0, 39) == 0);
                out_ready = ($urandom_range(0, 5) < ph);
                rt_valid  = NL'($urandom);
                rt_ready  = NL'($urandom) | NL'($urandom);
                rt_last   = NL'($urandom);
                rt_vxsat  = ($urandom_range(0, 7) == 0) ? NL'($urandom) : '0;
                for (int i = 0; i < NL; i++) begin
                    rt_index[i]  = 5'($urandom);
                    rt_strobe[i] = 16'($urandom);
                    rt_data[i]   = {$urandom, $urandom, $urandom, $urandom};
`ifdef RT_TRACE_PC_EN
                    rt_pc[i]     = $urandom;
`endif
                end
                step();
            end
        end

        idle();
        out_ready = 1'b1;
        for (int c = 0; c < DEPTH + 2; c++) step();
        chk("final_count", 256'(count), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
